game_session_ctrl: RTL and testbench

GAME_SESSION_CTRL -- requirements
Module: game_session_ctrl

---
 rtl/game_session_ctrl_pkg.sv | 50 +++++
 rtl/game_session_ctrl_if.sv | 21 ++
 rtl/game_session_ctrl_btn_edge_sync.sv | 31 +++
 rtl/game_session_ctrl.sv | 160 ++++++++++++++++
 tb/tb_game_session_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_session_ctrl_pkg.sv
// Shared types and constants for the game session controller.
package game_session_ctrl_pkg;

   localparam int unsigned BTN_W     = 3;
   localparam int unsigned LEVEL_W   = 3;
   localparam int unsigned PERIOD_W  = 16;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned DISP_W    = 64;
   localparam int unsigned GS_W      = 2;

   localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(7);

   // Session FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_PLAY = 2'd2,
      ST_OVER = 2'd3
   } state_e;

   // Externally visible gamestate encodings
   localparam logic [GS_W-1:0] GS_IDLE = 2'b00;
   localparam logic [GS_W-1:0] GS_PLAY = 2'b01;
   localparam logic [GS_W-1:0] GS_OVER = 2'b10;

   // Idle splash shown on the LED matrix
   localparam logic [DISP_W-1:0] SPLASH = 64'h0000_0018_1800_0000;

   // Score word reported by the game datapath
   typedef struct packed {
      logic [15:0] userid;
      logic [15:0] score;
   } game_data_t;

   // Tick period for a level: base - lvl*step, floored at floor_v, never underflows
   function automatic logic [PERIOD_W-1:0] tick_period(
      input logic [PERIOD_W-1:0] base,
      input logic [PERIOD_W-1:0] step,
      input logic [PERIOD_W-1:0] floor_v,
      input logic [LEVEL_W-1:0]  lvl
   );
      logic [PERIOD_W-1:0] red;
      red = PERIOD_W'(lvl) * step;
      if ((red < base) && ((base - red) > floor_v)) begin
         return base - red;
      end
      return floor_v;
   endfunction

endpackage

// File: rtl/game_session_ctrl_if.sv
// Controller <-> game datapath bus. master = session controller, slave = datapath.
interface game_session_ctrl_if;

   logic                                           game_rst_n;
   logic                                           game_tick;
   logic [game_session_ctrl_pkg::BTN_W-1:0]        game_buttons;
   logic                                           game_eog;
   game_session_ctrl_pkg::game_data_t              game_data;
   logic [game_session_ctrl_pkg::DISP_W-1:0]       game_display;

   modport master (
      output game_rst_n, game_tick, game_buttons,
      input  game_eog, game_data, game_display
   );

   modport slave (
      input  game_rst_n, game_tick, game_buttons,
      output game_eog, game_data, game_display
   );

endinterface

// File: rtl/game_session_ctrl_btn_edge_sync.sv
// btn_edge_sync: 2-flop synchroniser plus rising-edge detector per button bit.
// edge_c is combinational from flops; a raw edge shows up on edge_c after 2 clk.
module btn_edge_sync #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] raw,
   output logic [W-1:0] edge_c
);

   logic [W-1:0] meta;
   logic [W-1:0] sync;
   logic [W-1:0] prev;

   // Synchroniser chain and previous-value flop for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= '0;
         sync <= '0;
         prev <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
         prev <= sync;
      end
   end

   assign edge_c = sync & ~prev;

endmodule

// File: rtl/game_session_ctrl.sv
// game_session_ctrl: session FSM (IDLE/ARM/PLAY/OVER), level-scaled game tick,
// button conditioning and optional high-score tracking.
// Optional feature: define SESSION_HISCORE_EN to enable high-score tracking.
// TICK_MIN must be at least 2 (the counter reloads period-1 and ticks on 1->0).
module game_session_ctrl
   import game_session_ctrl_pkg::*;
#(
   parameter int unsigned TICK_BASE = 50,
   parameter int unsigned TICK_STEP = 5,
   parameter int unsigned TICK_MIN  = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BTN_W-1:0]    buttons,
   game_session_ctrl_if.master bus,
   output logic [GS_W-1:0]     gamestate,
   output logic [DISP_W-1:0]   disp_out,
   output logic [LEVEL_W-1:0]  level,
   output logic [DATA_W-1:0]   hiscore
);

   localparam logic [PERIOD_W-1:0] BASE_P = PERIOD_W'(TICK_BASE);
   localparam logic [PERIOD_W-1:0] STEP_P = PERIOD_W'(TICK_STEP);
   localparam logic [PERIOD_W-1:0] MIN_P  = PERIOD_W'(TICK_MIN);

   state_e              state;
   state_e              state_nxt;
   logic [GS_W-1:0]     gs_nxt;
   logic                rst_n_nxt;
   logic [DISP_W-1:0]   disp_nxt;
   logic [BTN_W-1:0]    btn_edge_c;
   logic                place_c;
   logic                start_c;
   logic                abort_c;
   logic                play_hold_c;
   logic [PERIOD_W-1:0] period_c;
   logic [PERIOD_W-1:0] cnt;

   btn_edge_sync #(.W(BTN_W)) u_btn_edge_sync (
      .clk    (clk),
      .rst    (rst),
      .raw    (buttons),
      .edge_c (btn_edge_c)
   );

   assign place_c     = btn_edge_c[0];
   assign start_c     = btn_edge_c[1];
   assign abort_c     = btn_edge_c[2];
   assign play_hold_c = (state == ST_PLAY) && (state_nxt == ST_PLAY);
   assign period_c    = tick_period(BASE_P, STEP_P, MIN_P, level);

   // Next state and the Moore outputs of the state being entered
   always_comb begin
      state_nxt = state;
      gs_nxt    = GS_IDLE;
      rst_n_nxt = 1'b0;
      disp_nxt  = SPLASH;
      case (state)
         ST_IDLE: if (start_c) state_nxt = ST_ARM;
         ST_ARM:  state_nxt = ST_PLAY;
         ST_PLAY: begin
            if (abort_c) begin
               state_nxt = ST_IDLE;
            end else if (bus.game_eog) begin
               state_nxt = ST_OVER;
            end
         end
         ST_OVER: if (start_c || abort_c) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      case (state_nxt)
         ST_ARM, ST_PLAY: begin
            gs_nxt    = GS_PLAY;
            rst_n_nxt = 1'b1;
            disp_nxt  = bus.game_display;
         end
         ST_OVER: begin
            gs_nxt    = GS_OVER;
            rst_n_nxt = 1'b1;
            disp_nxt  = bus.game_display;
         end
         default: ;
      endcase
   end

   // State register and registered session outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_IDLE;
         gamestate      <= GS_IDLE;
         bus.game_rst_n <= 1'b0;
         disp_out       <= SPLASH;
      end else begin
         state          <= state_nxt;
         gamestate      <= gs_nxt;
         bus.game_rst_n <= rst_n_nxt;
         disp_out       <= disp_nxt;
      end
   end

   // Tick counter: loaded in ARM, counts down in PLAY, reloads with the current period at 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt           <= '0;
         bus.game_tick <= 1'b0;
      end else begin
         bus.game_tick <= play_hold_c && (cnt == PERIOD_W'(1));
         if (state == ST_ARM) begin
            cnt <= period_c - PERIOD_W'(1);
         end else if (state == ST_PLAY) begin
            if (cnt == '0) begin
               cnt <= period_c - PERIOD_W'(1);
            end else begin
               cnt <= cnt - PERIOD_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   // Speed level: cleared on arming, bumped by place pulses in PLAY, saturating
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level <= '0;
      end else if ((state == ST_IDLE) && (state_nxt == ST_ARM)) begin
         level <= '0;
      end else if ((state == ST_PLAY) && place_c && (level != LEVEL_MAX)) begin
         level <= level + LEVEL_W'(1);
      end
   end

   // Button pulses forwarded to the datapath only while play continues
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.game_buttons <= '0;
      end else begin
         bus.game_buttons <= play_hold_c ? btn_edge_c : '0;
      end
   end

`ifdef SESSION_HISCORE_EN
   // Capture a strictly better score on the PLAY->OVER transition
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hiscore <= '0;
      end else if ((state == ST_PLAY) && (state_nxt == ST_OVER) &&
                   (bus.game_data.score > hiscore[15:0])) begin
         hiscore <= bus.game_data;
      end
   end
`else
   logic unused_game_data;

   // No score tracking in this build
   assign hiscore          = '0;
   assign unused_game_data = ^bus.game_data;
`endif

endmodule

// File: tb/tb_game_session_ctrl.sv
// Self-checking bench for game_session_ctrl (default tick parameters).
module tb_game_session_ctrl;
   import game_session_ctrl_pkg::*;

   localparam int unsigned TB_BASE    = 50;
   localparam int unsigned TB_STEP    = 5;
   localparam int unsigned TB_MIN     = 10;
   localparam int unsigned TICK_BOUND = 200;
   localparam logic [63:0] DISP       = 64'hDEAD_BEEF_0123_4567;

   logic        clk;
   logic        rst;
   logic [2:0]  buttons;
   logic [1:0]  gamestate;
   logic [63:0] disp_out;
   logic [2:0]  level;
   logic [31:0] hiscore;

   game_session_ctrl_if bus();

   game_session_ctrl #(
      .TICK_BASE (TB_BASE),
      .TICK_STEP (TB_STEP),
      .TICK_MIN  (TB_MIN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .buttons   (buttons),
      .bus       (bus),
      .gamestate (gamestate),
      .disp_out  (disp_out),
      .level     (level),
      .hiscore   (hiscore)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   int unsigned cyc         = 0;
   logic [2:0]  btn_or;
   logic [31:0] hs_model;
   int unsigned exp_q[$];
   logic [31:0] hs_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         btn_or = btn_or | bus.game_buttons;
      end
   endtask

   // Raw press of one cycle; returns just after the edge where the FSM reacts
   task automatic press(input int unsigned idx);
      btn_or       = '0;
      buttons[idx] = 1'b1;
      step(1);
      buttons[idx] = 1'b0;
      step(2);
   endtask

   task automatic wait_tick(output int unsigned t, output bit ok);
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < int'(TICK_BOUND); i++) begin
         step(1);
         if (bus.game_tick === 1'b1) begin
            ok = 1'b1;
            t  = cyc;
            break;
         end
      end
   endtask

   function automatic int unsigned exp_period(input int unsigned lvl);
      int p;
      p = int'(TB_BASE) - int'(lvl * TB_STEP);
      if (p < int'(TB_MIN)) p = int'(TB_MIN);
      return int'(p);
   endfunction

   function automatic logic [31:0] hs_update(input logic [31:0] hs, input logic [31:0] data);
`ifdef SESSION_HISCORE_EN
      if (data[15:0] > hs[15:0]) return data;
      return hs;
`else
      return 32'h0 & {hs[31:1], data[0]};
`endif
   endfunction

   task automatic test_reset();
      rst              = 1'b0;
      buttons          = '0;
      btn_or           = '0;
      bus.game_eog     = 1'b0;
      bus.game_data    = '0;
      bus.game_display = DISP;
      hs_model         = '0;
      step(3);
      vectors++; if (gamestate !== GS_IDLE) begin miscompares++; $display("FAIL rst_gamestate got=%h exp=%h", gamestate, GS_IDLE); end
      vectors++; if (bus.game_rst_n !== 1'b0) begin miscompares++; $display("FAIL rst_game_rst_n got=%b exp=0", bus.game_rst_n); end
      vectors++; if (bus.game_tick !== 1'b0) begin miscompares++; $display("FAIL rst_game_tick got=%b exp=0", bus.game_tick); end
      vectors++; if (bus.game_buttons !== 3'b000) begin miscompares++; $display("FAIL rst_game_buttons got=%b exp=000", bus.game_buttons); end
      vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL rst_level got=%0d exp=0", level); end
      vectors++; if (hiscore !== 32'h0) begin miscompares++; $display("FAIL rst_hiscore got=%h exp=0", hiscore); end
      vectors++; if (disp_out !== SPLASH) begin miscompares++; $display("FAIL rst_splash got=%h exp=%h", disp_out, SPLASH); end
      rst = 1'b1;
      step(2);
   endtask

   task automatic test_start();
      int unsigned t;
      int unsigned e;
      bit          ok;
      press(1);
      vectors++; if (btn_or !== 3'b000) begin miscompares++; $display("FAIL start_gated got=%b exp=000", btn_or); end
      vectors++; if (dut.state !== ST_ARM) begin miscompares++; $display("FAIL start_arm got=%0d exp=%0d", dut.state, ST_ARM); end
      vectors++; if (gamestate !== GS_PLAY || bus.game_rst_n !== 1'b1) begin miscompares++; $display("FAIL arm_outputs got=%h/%b exp=01/1", gamestate, bus.game_rst_n); end
      exp_q.push_back(cyc + TB_BASE);
      step(1);
      vectors++; if (dut.state !== ST_PLAY) begin miscompares++; $display("FAIL arm_one_cycle got=%0d exp=%0d", dut.state, ST_PLAY); end
      vectors++; if (disp_out !== DISP) begin miscompares++; $display("FAIL play_disp got=%h exp=%h", disp_out, DISP); end
      wait_tick(t, ok);
      e = exp_q.pop_front();
      vectors++; if (!ok || t !== e) begin miscompares++; $display("FAIL first_tick got_cycle=%0d exp_cycle=%0d seen=%b", t, e, ok); end
      step(1);
      vectors++; if (bus.game_tick !== 1'b0) begin miscompares++; $display("FAIL tick_width got=%b exp=0", bus.game_tick); end
   endtask

   task automatic test_levels();
      int unsigned t1;
      int unsigned t2;
      int unsigned e;
      int unsigned lvl_e;
      bit          ok1;
      bit          ok2;
      for (int i = 1; i <= 9; i++) begin
         press(0);
         lvl_e = (i > 7) ? 7 : i;
         vectors++; if (level !== 3'(lvl_e)) begin miscompares++; $display("FAIL level_%0d got=%0d exp=%0d", i, level, lvl_e); end
         if (i == 1) begin
            vectors++; if (btn_or !== 3'b001) begin miscompares++; $display("FAIL place_pulse got=%b exp=001", btn_or); end
         end
         exp_q.push_back(exp_period(lvl_e));
         wait_tick(t1, ok1);
         wait_tick(t2, ok2);
         e = exp_q.pop_front();
         vectors++; if (!ok1 || !ok2 || (t2 - t1) !== e) begin miscompares++; $display("FAIL period_lvl%0d got=%0d exp=%0d", lvl_e, t2 - t1, e); end
      end
   endtask

   task automatic test_hiscore();
      logic [31:0] tbl [4];
      logic [31:0] e;
      tbl[0] = 32'hABCD_0012;
      tbl[1] = 32'h1234_0012;
      tbl[2] = 32'h5555_0013;
      tbl[3] = 32'h7777_0001;
      for (int r = 0; r < 4; r++) begin
         bus.game_data = tbl[r];
         bus.game_eog  = 1'b1;
         hs_model      = hs_update(hs_model, tbl[r]);
         hs_q.push_back(hs_model);
         step(1);
         bus.game_eog = 1'b0;
         vectors++; if (gamestate !== GS_OVER) begin miscompares++; $display("FAIL over_%0d got=%h exp=%h", r, gamestate, GS_OVER); end
         e = hs_q.pop_front();
         vectors++; if (hiscore !== e) begin miscompares++; $display("FAIL hiscore_%0d got=%h exp=%h", r, hiscore, e); end
         press(((r % 2) == 1) ? 1 : 2);
         vectors++; if (gamestate !== GS_IDLE || disp_out !== SPLASH) begin miscompares++; $display("FAIL over_exit_%0d got=%h/%h exp=%h/%h", r, gamestate, disp_out, GS_IDLE, SPLASH); end
         press(1);
         step(1);
      end
   endtask

   task automatic test_abort_eog();
      bus.game_data = 32'h9999_FFFF;
      buttons[2]    = 1'b1;
      step(1);
      buttons[2]    = 1'b0;
      step(1);
      bus.game_eog  = 1'b1;
      step(1);
      bus.game_eog  = 1'b0;
      vectors++; if (dut.state !== ST_IDLE || gamestate !== GS_IDLE) begin miscompares++; $display("FAIL abort_wins got=%0d/%h exp=%0d/%h", dut.state, gamestate, ST_IDLE, GS_IDLE); end
      vectors++; if (hiscore !== hs_model) begin miscompares++; $display("FAIL abort_hiscore got=%h exp=%h", hiscore, hs_model); end
      vectors++; if (bus.game_buttons !== 3'b000) begin miscompares++; $display("FAIL abort_gated got=%b exp=000", bus.game_buttons); end
   endtask

   task automatic test_reset_mid_play();
      bit tick_seen;
      bit busy_seen;
      press(1);
      step(49);
      vectors++; if (bus.game_tick !== 1'b0 || dut.state !== ST_PLAY) begin miscompares++; $display("FAIL pre_reset got=%b/%0d exp=0/%0d", bus.game_tick, dut.state, ST_PLAY); end
      rst = 1'b0;
      hs_model = '0;
      #1;
      vectors++; if (gamestate !== GS_IDLE || bus.game_rst_n !== 1'b0 || level !== 3'd0) begin miscompares++; $display("FAIL async_reset got=%h/%b/%0d exp=00/0/0", gamestate, bus.game_rst_n, level); end
      vectors++; if (hiscore !== hs_model || bus.game_buttons !== 3'b000) begin miscompares++; $display("FAIL async_reset_misc got=%h/%b exp=%h/000", hiscore, bus.game_buttons, hs_model); end
      tick_seen = 1'b0;
      busy_seen = 1'b0;
      for (int i = 0; i < 63; i++) begin
         if (i == 3) rst = 1'b1;
         step(1);
         if (bus.game_tick !== 1'b0) tick_seen = 1'b1;
         if (gamestate !== GS_IDLE || dut.state !== ST_IDLE) busy_seen = 1'b1;
      end
      vectors++; if (tick_seen !== 1'b0) begin miscompares++; $display("FAIL reset_tick_escape got=%b exp=0", tick_seen); end
      vectors++; if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL reset_idle got=%b exp=0", busy_seen); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_levels();
      test_hiscore();
      test_abort_eog();
      test_reset_mid_play();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
